// File: rtl/log_mac_accum_if.sv
// Beat/result bus of log_mac_accum: product beats in, one dot-product result out.
interface log_mac_accum_if #(
    parameter int LANES = 4,
    parameter int PW    = 16,
    parameter int AW    = 24,
    parameter int CW    = 8
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*PW-1:0]   in_prod;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [AW-1:0]         out_sum;
    logic [CW-1:0]         out_beats;
    logic                  out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_beats, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_beats, out_ovf
    );
endinterface

// File: rtl/log_mac_accum.sv
// Adder-tree + accumulator behind the log multiplier array; one result per in_last vector.
// Optional macro ACC_SAT_EN: accumulator clamps at all-ones on carry-out instead of wrapping.
module log_mac_accum #(
    parameter int LANES = 4,
    parameter int PW    = 16,
    parameter int AW    = 24,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    log_mac_accum_if.slave   bus
);
    localparam int TW = PW + $clog2(LANES);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic            in_ready_s;
    logic            out_valid_s;
    logic            accept_s;
    logic            finish_s;

    logic [TW-1:0]   tree_s;
    logic [TW-1:0]   tree_r;
    logic            tvalid_r;
    logic [AW-1:0]   acc_r;
    logic [CW-1:0]   cnt_r;
    logic            ovf_r;
    logic [AW-1:0]   tree_add_s;
    logic [AW:0]     acc_wide_s;
    logic            ovf_add_s;
    logic [AW-1:0]   acc_add_s;

    logic [AW-1:0]   out_sum_r;
    logic [CW-1:0]   out_beats_r;
    logic            out_ovf_r;

    assign accept_s = bus.in_valid & in_ready_s;
    // FLUSH waits for the last tree value to be absorbed, so acc alone is the final result.
    assign finish_s = (state_r == FLUSH) & ~tvalid_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ACC;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ACC: begin
                if (accept_s && bus.in_last) state_next_s = FLUSH;
                else                         state_next_s = ACC;
            end
            FLUSH: begin
                if (finish_s) state_next_s = HOLD;
                else          state_next_s = FLUSH;
            end
            HOLD: begin
                if (bus.out_ready) state_next_s = ACC;
                else               state_next_s = HOLD;
            end
            default: state_next_s = ACC;
        endcase
    end

    // Handshake outputs decoded from the state register only
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            ACC:     in_ready_s  = 1'b1;
            FLUSH:   in_ready_s  = 1'b0;
            HOLD:    out_valid_s = 1'b1;
            default: in_ready_s  = 1'b0;
        endcase
    end

    // Unsigned lane reduction
    always_comb begin
        tree_s = {TW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            tree_s = tree_s + TW'(bus.in_prod[i*PW +: PW]);
        end
    end

    // Accumulate step with carry detection; clamps or wraps depending on build
    always_comb begin
        if (tvalid_r) tree_add_s = AW'(tree_r);
        else          tree_add_s = {AW{1'b0}};
        acc_wide_s = {1'b0, acc_r} + {1'b0, tree_add_s};
        ovf_add_s  = ovf_r | acc_wide_s[AW];
`ifdef ACC_SAT_EN
        if (ovf_add_s) acc_add_s = {AW{1'b1}};
        else           acc_add_s = acc_wide_s[AW-1:0];
`else
        acc_add_s  = acc_wide_s[AW-1:0];
`endif
    end

    // Tree register, accumulator, beat counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tree_r      <= {TW{1'b0}};
            tvalid_r    <= 1'b0;
            acc_r       <= {AW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            ovf_r       <= 1'b0;
            out_sum_r   <= {AW{1'b0}};
            out_beats_r <= {CW{1'b0}};
            out_ovf_r   <= 1'b0;
        end else begin
            tvalid_r <= accept_s;
            if (accept_s) begin
                tree_r <= tree_s;
            end
            if (finish_s) begin
                out_sum_r   <= acc_add_s;
                out_beats_r <= cnt_r;
                out_ovf_r   <= ovf_add_s;
                acc_r       <= {AW{1'b0}};
                cnt_r       <= {CW{1'b0}};
                ovf_r       <= 1'b0;
            end else begin
                if (tvalid_r) begin
                    acc_r <= acc_add_s;
                    ovf_r <= ovf_add_s;
                end
                if (accept_s && (cnt_r != {CW{1'b1}})) begin
                    cnt_r <= cnt_r + CW'(1'b1);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_sum   = out_sum_r;
    assign bus.out_beats = out_beats_r;
    assign bus.out_ovf   = out_ovf_r;
endmodule

// File: tb/tb_log_mac_accum.sv
// Directed bench for log_mac_accum: single-beat vector table plus multi-cycle corner sequences.
module tb_log_mac_accum;
    logic clk;
    logic rst;

    log_mac_accum_if #(.LANES(4), .PW(16), .AW(24), .CW(8)) bus ();
    log_mac_accum_if #(.LANES(4), .PW(16), .AW(18), .CW(8)) bus2 ();

    log_mac_accum #(.LANES(4), .PW(16), .AW(24), .CW(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    log_mac_accum #(.LANES(4), .PW(16), .AW(18), .CW(8)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] prod;
        logic [31:0] sum;
    } vec_t;

    vec_t vecs[6];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   ready_bad = 0;
    int   lat;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic send(input logic [63:0] prod, input int n, input bit bubble);
        for (int i = 0; i < n; i++) begin
            if (!bus.in_ready) ready_bad++;
            bus.in_valid = 1'b1;
            bus.in_prod  = prod;
            bus.in_last  = (i == n - 1);
            step();
            if (bubble && (i < n - 1)) begin
                bus.in_valid = 1'b0;
                bus.in_prod  = {4{16'hFFFF}};
                bus.in_last  = 1'b1;
                step();
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_prod  = 64'd0;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 20) begin
            step();
            cycles++;
        end
        if (!bus.out_valid) check("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_sum"},   32'(bus.out_sum),   32'd0);
        check({tag, "_out_beats"}, 32'(bus.out_beats), 32'd0);
        check({tag, "_out_ovf"},   32'(bus.out_ovf),   32'd0);
    endtask

    initial begin
        vecs[0] = '{prod: {16'd4, 16'd3, 16'd2, 16'd1},                 sum: 32'd10};
        vecs[1] = '{prod: {16'd5, 16'd5, 16'd5, 16'd5},                 sum: 32'd20};
        vecs[2] = '{prod: {4{16'hFFFF}},                                sum: 32'd262140};
        vecs[3] = '{prod: 64'd0,                                        sum: 32'd0};
        vecs[4] = '{prod: {16'd1, 16'd0, 16'd0, 16'hFE01},              sum: 32'd65026};
        vecs[5] = '{prod: {4{16'h8000}},                                sum: 32'd131072};

        rst = 1'b1;
        bus.in_valid  = 1'b0; bus.in_prod  = 64'd0; bus.in_last  = 1'b0; bus.out_ready  = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_prod = 64'd0; bus2.in_last = 1'b0; bus2.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Idle after reset
        for (int c = 0; c < 10; c++) begin
            step();
            check("idle_in_ready",  32'(bus.in_ready),  32'd1);
            check("idle_out_valid", 32'(bus.out_valid), 32'd0);
            check("idle_out_sum",   32'(bus.out_sum),   32'd0);
        end

        // Single-beat vectors with latency and turnaround checks
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            send(vecs[k].prod, 1, 1'b0);
            check("flush_in_ready", 32'(bus.in_ready), 32'd0);
            wait_result(lat);
            check("latency",   32'(lat),           32'd2);
            check("sum",       32'(bus.out_sum),   vecs[k].sum);
            check("beats",     32'(bus.out_beats), 32'd1);
            check("ovf",       32'(bus.out_ovf),   32'd0);
            step();
            check("after_hs_in_ready",  32'(bus.in_ready),  32'd1);
            check("after_hs_out_valid", 32'(bus.out_valid), 32'd0);
        end

        // 64 back-to-back beats, then 5 cycles of backpressure
        bus.out_ready = 1'b0;
        ready_bad = 0;
        send({4{16'hFE01}}, 64, 1'b0);
        check("b2b_ready_drops", 32'(ready_bad), 32'd0);
        wait_result(lat);
        check("b2b_sum",   32'(bus.out_sum),   32'h00FE0100);
        check("b2b_beats", 32'(bus.out_beats), 32'd64);
        check("b2b_ovf",   32'(bus.out_ovf),   32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_sum",       32'(bus.out_sum),   32'h00FE0100);
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        send({4{16'd5}}, 1, 1'b0);
        wait_result(lat);
        check("after_bp_sum",   32'(bus.out_sum),   32'd20);
        check("after_bp_beats", 32'(bus.out_beats), 32'd1);
        step();

        // Bubbles with garbage on idle cycles
        send({4{16'd1}}, 3, 1'b1);
        wait_result(lat);
        check("bubble_sum",   32'(bus.out_sum),   32'd12);
        check("bubble_beats", 32'(bus.out_beats), 32'd3);
        step();

        // Reset in FLUSH
        send({16'd4, 16'd3, 16'd2, 16'd1}, 1, 1'b0);
        check("pre_rst_flush", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_flush");

        // Reset in HOLD
        bus.out_ready = 1'b0;
        send({16'd4, 16'd3, 16'd2, 16'd1}, 2, 1'b0);
        wait_result(lat);
        check("pre_rst_hold_sum", 32'(bus.out_sum), 32'd20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rst_hold");

        // Partial vector discarded by reset
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_prod = {4{16'd100}}; bus.in_last = 1'b0;
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        send({16'd4, 16'd3, 16'd2, 16'd1}, 1, 1'b0);
        wait_result(lat);
        check("discard_sum",   32'(bus.out_sum),   32'd10);
        check("discard_beats", 32'(bus.out_beats), 32'd1);
        step();

        // Overflow on the AW=18 instance
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_prod  = {4{16'hFFFF}};
            bus2.in_last  = (i == 4);
            step();
        end
        bus2.in_valid = 1'b0;
        bus2.in_last  = 1'b0;
        lat = 0;
        while (!bus2.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("ovf_latency", 32'(lat), 32'd2);
`ifdef ACC_SAT_EN
        check("ovf_sum", 32'(bus2.out_sum), 32'd262143);
`else
        check("ovf_sum", 32'(bus2.out_sum), 32'd262124);
`endif
        check("ovf_flag",  32'(bus2.out_ovf),   32'd1);
        check("ovf_beats", 32'(bus2.out_beats), 32'd5);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
